pc_unit: RTL and testbench

//  Parametrised program-counter unit for the single-cycle core. Replaces the

---
 rtl/pc_pkg.sv | 30 +++
 rtl/pc_next_sel.sv | 55 +++++
 rtl/pc_unit.sv | 103 ++++++++++
 tb/tb_pc_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and ISA-step constants for the program-counter unit.
// PC_UNIT_RVC_EN selects the compressed-ISA step and alignment rule.
package pc_pkg;

    typedef enum logic {
        PC_RUN,
        PC_HALT
    } pc_state_e;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_HOLD,
        SEL_REDIR,
        SEL_TRAP,
        SEL_EPC
    } pc_sel_e;

`ifdef PC_UNIT_RVC_EN
    localparam int unsigned STEP          = 2;
    localparam logic [1:0]  MISALIGN_MASK = 2'b01;
`else
    localparam int unsigned STEP          = 4;
    localparam logic [1:0]  MISALIGN_MASK = 2'b11;
`endif

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits & MISALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Priority encoder: requests plus current state -> next-PC source and next state.
// Purely combinational; the top level owns all registers.
module pc_next_sel
    import pc_pkg::*;
(
    input  pc_state_e state_q,
    input  logic      trap_req,
    input  logic      mret_req,
    input  logic      redirect_valid,
    input  logic      redirect_misaligned,
    input  logic      halt_req,
    input  logic      stall,
    input  logic      wake,
    output pc_sel_e   sel,
    output pc_state_e next_state,
    output logic      mis_trap
);

    always_comb begin
        sel        = SEL_HOLD;
        next_state = state_q;
        mis_trap   = 1'b0;
        if (state_q == PC_RUN) begin
            if (trap_req) begin
                sel = SEL_TRAP;
            end else if (mret_req) begin
                sel = SEL_EPC;
            end else if (redirect_valid) begin
                // A misaligned target becomes a trap instead of a fetch
                if (redirect_misaligned) begin
                    sel      = SEL_TRAP;
                    mis_trap = 1'b1;
                end else begin
                    sel = SEL_REDIR;
                end
            end else if (halt_req) begin
                sel        = SEL_HOLD;
                next_state = PC_HALT;
            end else if (stall) begin
                sel = SEL_HOLD;
            end else begin
                sel = SEL_SEQ;
            end
        end else begin
            if (trap_req) begin
                sel        = SEL_TRAP;
                next_state = PC_RUN;
            end else if (wake) begin
                sel        = SEL_SEQ;
                next_state = PC_RUN;
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC registers, trap/return bookkeeping, halt/wake.
// Build with PC_UNIT_RVC_EN defined for 2-byte steps and bit0-only alignment.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned       XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter int unsigned       TRAP_ALIGN   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            mret_req,
    input  logic            halt_req,
    input  logic            wake,
    output logic [XLEN-1:0] curr_pc,
    output logic [XLEN-1:0] pc_plus_step,
    output logic            pc_valid,
    output logic [XLEN-1:0] epc,
    output logic            misaligned,
    output logic [XLEN-1:0] bad_addr
);

    localparam logic [XLEN-1:0] STEP_W    = XLEN'(STEP);
    localparam logic [XLEN-1:0] TRAP_MASK = ~((XLEN'(1) << TRAP_ALIGN) - XLEN'(1));

    pc_state_e       state_q, state_d, next_state;
    pc_sel_e         sel;
    logic            mis_trap;
    logic [XLEN-1:0] curr_pc_q, curr_pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] bad_addr_q, bad_addr_d;
    logic            misaligned_q, misaligned_d;
    logic [XLEN-1:0] trap_target;

    pc_next_sel u_next_sel (
        .state_q            (state_q),
        .trap_req           (trap_req),
        .mret_req           (mret_req),
        .redirect_valid     (redirect_valid),
        .redirect_misaligned(is_misaligned(redirect_target[1:0])),
        .halt_req           (halt_req),
        .stall              (stall),
        .wake               (wake),
        .sel                (sel),
        .next_state         (next_state),
        .mis_trap           (mis_trap)
    );

    assign pc_plus_step = curr_pc_q + STEP_W;
    assign trap_target  = trap_vector & TRAP_MASK;

    always_comb begin
        curr_pc_d    = curr_pc_q;
        epc_d        = epc_q;
        bad_addr_d   = bad_addr_q;
        misaligned_d = 1'b0;
        state_d      = next_state;
        case (sel)
            SEL_SEQ:   curr_pc_d = pc_plus_step;
            SEL_HOLD:  curr_pc_d = curr_pc_q;
            SEL_REDIR: curr_pc_d = redirect_target;
            SEL_EPC:   curr_pc_d = epc_q;
            SEL_TRAP: begin
                curr_pc_d = trap_target;
                // From HALT the halted instruction is complete, so return past it
                epc_d     = (state_q == PC_HALT) ? pc_plus_step : curr_pc_q;
            end
            default:   curr_pc_d = curr_pc_q;
        endcase
        if (mis_trap) begin
            bad_addr_d   = redirect_target;
            misaligned_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= PC_RUN;
            curr_pc_q    <= RESET_VECTOR;
            epc_q        <= '0;
            bad_addr_q   <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            curr_pc_q    <= curr_pc_d;
            epc_q        <= epc_d;
            bad_addr_q   <= bad_addr_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign curr_pc    = curr_pc_q;
    assign epc        = epc_q;
    assign bad_addr   = bad_addr_q;
    assign misaligned = misaligned_q;
    assign pc_valid   = !reset && (state_q == PC_RUN);

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit (default build: STEP=4, 4-byte alignment).
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid, trap_req, mret_req, halt_req, wake;
    logic [31:0] redirect_target, trap_vector;
    logic [31:0] curr_pc, pc_plus_step, epc, bad_addr;
    logic        pc_valid, misaligned;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .trap_req       (trap_req),
        .trap_vector    (trap_vector),
        .mret_req       (mret_req),
        .halt_req       (halt_req),
        .wake           (wake),
        .curr_pc        (curr_pc),
        .pc_plus_step   (pc_plus_step),
        .pc_valid       (pc_valid),
        .epc            (epc),
        .misaligned     (misaligned),
        .bad_addr       (bad_addr)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic [31:0] bad;
        logic        mis;
        logic        vld;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference state, advanced once per cycle from the architectural rules
    logic [31:0] m_pc, m_epc, m_bad;
    bit          m_mis, m_halted;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cycle(input bit rst, input bit tr, input bit mr, input bit rv,
                         input logic [31:0] rt, input logic [31:0] tv,
                         input bit hr, input bit st, input bit wk);
        exp_t e;
        @(negedge clk);
        reset = rst; trap_req = tr; mret_req = mr; redirect_valid = rv;
        redirect_target = rt; trap_vector = tv; halt_req = hr; stall = st; wake = wk;
        m_mis = 1'b0;
        if (rst) begin
            m_pc = 32'h0; m_epc = 32'h0; m_bad = 32'h0; m_halted = 1'b0;
        end else if (!m_halted) begin
            if (tr) begin
                m_epc = m_pc; m_pc = {tv[31:2], 2'b00};
            end else if (mr) begin
                m_pc = m_epc;
            end else if (rv) begin
                if (rt % 4 != 0) begin
                    m_epc = m_pc; m_bad = rt; m_mis = 1'b1; m_pc = {tv[31:2], 2'b00};
                end else begin
                    m_pc = rt;
                end
            end else if (hr) begin
                m_halted = 1'b1;
            end else if (!st) begin
                m_pc = m_pc + 32'd4;
            end
        end else begin
            if (tr) begin
                m_epc = m_pc + 32'd4; m_pc = {tv[31:2], 2'b00}; m_halted = 1'b0;
            end else if (wk) begin
                m_pc = m_pc + 32'd4; m_halted = 1'b0;
            end
        end
        e.pc = m_pc; e.epc = m_epc; e.bad = m_bad; e.mis = m_mis;
        e.vld = !rst && !m_halted;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    endtask

    // Monitor: outputs are sampled just after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("curr_pc", curr_pc, e.pc);
                chk("pc_plus_step", pc_plus_step, e.pc + 32'd4);
                chk("epc", epc, e.epc);
                chk("bad_addr", bad_addr, e.bad);
                chk("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
                chk("pc_valid", {31'b0, pc_valid}, {31'b0, e.vld});
            end
        end
    end

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; trap_req = 1'b0;
        mret_req = 1'b0; halt_req = 1'b0; wake = 1'b0;
        redirect_target = 32'h0; trap_vector = 32'h0;

        cycle(1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
        cycle(1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
        idle(4);                                                  // 0 -> 0x10
        cycle(0, 0, 0, 1, 32'h40, 32'h0, 0, 1, 0);                // redirect beats stall
        cycle(0, 0, 0, 1, 32'h20, 32'h0, 0, 0, 0);
        cycle(0, 0, 0, 1, 32'h42, 32'h207, 0, 0, 0);              // misaligned redirect
        idle(2);
        cycle(0, 0, 0, 1, 32'h30, 32'h0, 0, 0, 0);
        cycle(0, 1, 1, 0, 32'h0, 32'h103, 0, 0, 0);               // trap beats mret
        cycle(0, 0, 1, 0, 32'h0, 32'h0, 0, 0, 0);                 // mret -> 0x30
        cycle(0, 0, 0, 1, 32'h50, 32'h0, 0, 0, 0);
        cycle(0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0);                 // halt at 0x50
        for (int i = 0; i < 5; i++)
            cycle(0, 0, i[0], 1, 32'h80, 32'h0, 0, 1, 0);         // ignored while halted
        cycle(0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 1);                 // wake -> 0x54
        cycle(0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0);
        cycle(0, 1, 0, 0, 32'h0, 32'h2F1, 0, 0, 0);               // trap out of halt
        cycle(0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0, 0, 0, 0);
        idle(1);                                                  // wraps to 0
        cycle(0, 0, 0, 1, 32'h0, 32'h0, 0, 0, 0);
        cycle(1, 1, 0, 0, 32'h0, 32'h400, 0, 0, 0);               // reset beats trap
        idle(2);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] rt;
            rt = $urandom;
            if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 4) == 0,
                  rt, $urandom, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        @(posedge clk);
        #3;
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
